// File: rtl/seller_pkg.sv
// Shared definitions for the seller vending controller: state encoding,
// price and coin denominations, plus a small credit decode helper.
package seller_pkg;

   // Credit states; the encoding is fixed and visible on the debug state register.
   typedef enum logic [1:0] {
      S0  = 2'b00,   // no credit
      S5  = 2'b01,   // 5 units credited
      S10 = 2'b10,   // 10 units credited
      S15 = 2'b11    // vend cycle
   } state_t;

   localparam int PRICE   = 15;
   localparam int COIN_LO = 5;
   localparam int COIN_HI = 10;

   // Credit represented by a state, used for readability of the next-state logic.
   function automatic int credit_of(input state_t s);
      case (s)
         S0:      credit_of = 0;
         S5:      credit_of = COIN_LO;
         S10:     credit_of = COIN_HI;
         default: credit_of = PRICE;
      endcase
   endfunction

endpackage : seller_pkg

// File: rtl/seller.sv
// Coin-operated vending controller. Moore FSM accumulating 5/10-unit coin
// strobes; issues a one-cycle dispense when credit reaches 15 and a
// simultaneous change pulse when the vend was reached from 20 units.
module seller
   import seller_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic coin_5,
   input  logic coin_10,
   output logic dispense,
   output logic change
);

   // The state register keeps its plain name so it can be probed for debug.
   state_t state;
   state_t state_d;
   logic   change_flag_q;
   logic   change_flag_d;

   // Coin qualification: a 10-unit coin wins, a simultaneous 5-unit coin is dropped.
   logic take_10;
   logic take_5;

   // Decode which coin, if any, is credited this cycle.
   always_comb begin
      take_10 = coin_10;
      take_5  = coin_5 && !coin_10;
   end

   // Next-state and change-flag computation; absence of a coin holds the credit.
   always_comb begin
      state_d       = state;
      change_flag_d = change_flag_q;
      case (state)
         S0: begin
            if (take_10)
               state_d = S10;
            else if (take_5)
               state_d = S5;
         end
         S5: begin
            if (take_10) begin
               state_d       = S15;
               change_flag_d = 1'b0;
            end else if (take_5) begin
               state_d = S10;
            end
         end
         S10: begin
            // 10 + 10 overshoots the price by one coin, so a 5 is returned.
            if (take_10) begin
               state_d       = S15;
               change_flag_d = 1'b1;
            end else if (take_5) begin
               state_d       = S15;
               change_flag_d = 1'b0;
            end
         end
         default: begin
            // Vend lasts one cycle; a coin arriving now is credited as if from empty.
            change_flag_d = 1'b0;
            if (take_10)
               state_d = S10;
            else if (take_5)
               state_d = S5;
            else
               state_d = S0;
         end
      endcase
   end

   // State and change-flag registers with synchronous reset dominating coins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S0;
         change_flag_q <= 1'b0;
      end else begin
         state         <= state_d;
         change_flag_q <= change_flag_d;
      end
   end

   // Moore output decode straight from registered state, so outputs are glitch-free.
   always_comb begin
      dispense = (state == S15);
      change   = (state == S15) && change_flag_q;
   end

endmodule : seller

// File: tb/tb_seller.sv
// Scoreboard bench for seller: the driver applies one directed vector per
// cycle and queues the hand-computed post-edge result; a monitor pops and
// compares on each falling edge.
module tb_seller;

   logic clk;
   logic rst;
   logic coin_5;
   logic coin_10;
   logic dispense;
   logic change;

   typedef struct {
      logic       rst;
      logic       c5;
      logic       c10;
      logic [1:0] st;
      logic       disp;
      logic       chg;
      int         id;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   seller dut (
      .clk      (clk),
      .rst      (rst),
      .coin_5   (coin_5),
      .coin_10  (coin_10),
      .dispense (dispense),
      .change   (change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic c5, input logic c10,
                      input logic [1:0] st, input logic d, input logic c);
      vec_t v;
      v.rst = r; v.c5 = c5; v.c10 = c10;
      v.st = st; v.disp = d; v.chg = c;
      v.id = vecs.size();
      vecs.push_back(v);
   endtask

   // Monitor: compare DUT against the oldest queued expectation.
   initial begin
      vec_t e;
      logic [1:0] st_now;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            st_now = dut.state;
            n_checks++;
            if (st_now !== e.st) begin
               n_fail++;
               $display("FAIL state v%0d: got %b expected %b", e.id, st_now, e.st);
            end
            n_checks++;
            if (dispense !== e.disp) begin
               n_fail++;
               $display("FAIL dispense v%0d: got %b expected %b", e.id, dispense, e.disp);
            end
            n_checks++;
            if (change !== e.chg) begin
               n_fail++;
               $display("FAIL change v%0d: got %b expected %b", e.id, change, e.chg);
            end
            n_checks++;
            if (change && !dispense) begin
               n_fail++;
               $display("FAIL change_without_dispense v%0d: change %b dispense %b", e.id, change, dispense);
            end
            $display("v%0d rst=%b c5=%b c10=%b -> state=%b dispense=%b change=%b",
                     e.id, e.rst, e.c5, e.c10, st_now, dispense, change);
         end
      end
   end

   // Driver: build directed table, apply a vector per cycle, queue expectations.
   initial begin
      rst = 1'b1; coin_5 = 1'b0; coin_10 = 1'b0;

      // three 5-unit coins with idle gaps
      add(1,0,0, 2'b00,0,0);
      add(0,1,0, 2'b01,0,0);
      add(0,0,0, 2'b01,0,0);
      add(0,1,0, 2'b10,0,0);
      add(0,0,0, 2'b10,0,0);
      add(0,1,0, 2'b11,1,0);
      add(0,0,0, 2'b00,0,0);
      // 10 then 5
      add(1,0,0, 2'b00,0,0);
      add(0,0,1, 2'b10,0,0);
      add(0,1,0, 2'b11,1,0);
      add(0,0,0, 2'b00,0,0);
      // 5 then 10
      add(1,0,0, 2'b00,0,0);
      add(0,1,0, 2'b01,0,0);
      add(0,0,1, 2'b11,1,0);
      add(0,0,0, 2'b00,0,0);
      // 10, idle, 10 without reset: change returned
      add(0,0,1, 2'b10,0,0);
      add(0,0,0, 2'b10,0,0);
      add(0,0,1, 2'b11,1,1);
      add(0,0,0, 2'b00,0,0);
      // reset in S10, then in S15
      add(0,0,1, 2'b10,0,0);
      add(1,0,0, 2'b00,0,0);
      add(0,1,0, 2'b01,0,0);
      add(0,0,1, 2'b11,1,0);
      add(1,0,0, 2'b00,0,0);
      add(0,0,0, 2'b00,0,0);
      add(0,1,0, 2'b01,0,0);
      // reset overrides a coin in the same cycle
      add(1,1,0, 2'b00,0,0);
      add(0,0,0, 2'b00,0,0);
      // both coins from S0 -> S10
      add(0,1,1, 2'b10,0,0);
      add(0,0,0, 2'b10,0,0);
      add(0,1,0, 2'b11,1,0);
      // coin_5 during S15 -> S5, no second dispense
      add(0,1,0, 2'b01,0,0);
      add(0,0,0, 2'b01,0,0);
      add(0,0,1, 2'b11,1,0);
      // coin_10 during S15 -> S10, then change vend, then flag cleared
      add(0,0,1, 2'b10,0,0);
      add(0,0,1, 2'b11,1,1);
      add(0,0,1, 2'b10,0,0);
      add(0,1,0, 2'b11,1,0);
      add(0,0,0, 2'b00,0,0);
      // coin held high three cycles counts three times
      add(0,1,0, 2'b01,0,0);
      add(0,1,0, 2'b10,0,0);
      add(0,1,0, 2'b11,1,0);
      add(0,0,0, 2'b00,0,0);
      // both coins in S5 and in S10: 10 wins
      add(0,1,0, 2'b01,0,0);
      add(0,1,1, 2'b11,1,0);
      add(0,0,1, 2'b10,0,0);
      add(0,1,1, 2'b11,1,1);
      add(0,0,0, 2'b00,0,0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; coin_5 = vecs[i].c5; coin_10 = vecs[i].c10;
         @(posedge clk);
         exp_q.push_back(vecs[i]);
         #1;
      end
      rst = 1'b0; coin_5 = 1'b0; coin_10 = 1'b0;

      for (int k = 0; k < 10 && exp_q.size() != 0; k++)
         @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seller
